// File: rtl/multi_timer_divider_pkg.sv
// Shared constants and helpers for the multi-channel timer divider.
package multi_timer_divider_pkg;

   localparam int unsigned DEFAULT_N_CH  = 4;
   localparam int unsigned DEFAULT_CNT_W = 24;

   // Width of a channel index; never below one bit, so a single channel still has a select.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/multi_timer_divider_if.sv
// Control/status bundle of the multi-channel timer divider.
interface multi_timer_divider_if
   import multi_timer_divider_pkg::*;
#(
   parameter int unsigned N_CH  = DEFAULT_N_CH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
);

   localparam int unsigned CH_W = clog2_min1(N_CH);

   logic              enable;
   logic              sync_clr;
   logic              div_we;
   logic [CH_W-1:0]   div_sel;
   logic [CNT_W-1:0]  div_val;
   logic [N_CH-1:0]   tick_out;
   logic [N_CH-1:0]   clk_out;

   modport master (
      output enable, sync_clr, div_we, div_sel, div_val,
      input  tick_out, clk_out
   );

   modport slave (
      input  enable, sync_clr, div_we, div_sel, div_val,
      output tick_out, clk_out
   );

endinterface

// File: rtl/timer_div_channel.sv
// One divider channel: programmable divide value, counter, tick pulse and square wave.
module timer_div_channel #(
   parameter int unsigned            CNT_W       = 24,
   parameter logic [CNT_W-1:0]       DEFAULT_DIV = {CNT_W{1'b1}}
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             sync_clr,
   input  logic             wr,
   input  logic [CNT_W-1:0] wdata,
   output logic             tick,
   output logic             sq
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   // Next state; terminal count compares against the pre-edge divide value.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = wr ? wdata : div_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (sync_clr) begin
         cnt_d = '0;
         sq_d  = 1'b0;
      end else if (enable) begin
         if (cnt_q == div_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = ~sq_q;
         end else if (cnt_q > div_q) begin
            // Divide value shrank below the count: restart silently.
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State registers; reset also restores the default divide value.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         div_q  <= DEFAULT_DIV;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick = tick_q;
   assign sq   = sq_q;

endmodule

// File: rtl/multi_timer_divider.sv
// N_CH independent tick / square-wave clock-enable generators sharing enable and phase clear.
module multi_timer_divider
   import multi_timer_divider_pkg::*;
#(
   parameter int unsigned      N_CH        = DEFAULT_N_CH,
   parameter int unsigned      CNT_W       = DEFAULT_CNT_W,
   parameter logic [CNT_W-1:0] DEFAULT_DIV = {CNT_W{1'b1}}
) (
   input logic                   clk_in,
   input logic                   reset,
   multi_timer_divider_if.slave  bus
);

   localparam int unsigned CH_W = clog2_min1(N_CH);

   logic [N_CH-1:0] wr;
   logic [N_CH-1:0] tick_vec;
   logic [N_CH-1:0] sq_vec;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Selects at or above N_CH match no channel and are dropped.
      assign wr[i] = bus.div_we && (bus.div_sel == CH_W'(i));

      timer_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in   (clk_in),
         .reset    (reset),
         .enable   (bus.enable),
         .sync_clr (bus.sync_clr),
         .wr       (wr[i]),
         .wdata    (bus.div_val),
         .tick     (tick_vec[i]),
         .sq       (sq_vec[i])
      );
   end

   assign bus.tick_out = tick_vec;
   assign bus.clk_out  = sq_vec;

endmodule
